// File: rtl/cpu_pkg.sv
// Shared encodings and default vectors for the MIPS core front end.
// Holds the pc_src codes, privilege state enum and reset/exception vectors.
package cpu_pkg;

    localparam logic [2:0] PC_SRC_SEQ   = 3'd0;
    localparam logic [2:0] PC_SRC_BR    = 3'd1;
    localparam logic [2:0] PC_SRC_J     = 3'd2;
    localparam logic [2:0] PC_SRC_JR    = 3'd3;
    localparam logic [2:0] PC_SRC_ILLOP = 3'd4;

    typedef enum logic {
        S_USER   = 1'b0,
        S_KERNEL = 1'b1
    } state_e;

    localparam logic [31:0] RESET_VEC = 32'h8000_0000;
    localparam logic [31:0] ILLOP_VEC = 32'h8000_0004;
    localparam logic [31:0] XADR_VEC  = 32'h8000_0008;

endpackage

// File: rtl/pc_next_mux.sv
// Combinational next-PC and privilege selection for pc_sequencer.
// Priority: illop, pending irq in user mode, then the pc_src choice.
module pc_next_mux
    import cpu_pkg::*;
#(
    parameter int                 ADDR_W    = 32,
    parameter int                 JT_W      = 26,
    parameter logic [ADDR_W-1:0]  ILLOP_VEC = ADDR_W'(cpu_pkg::ILLOP_VEC),
    parameter logic [ADDR_W-1:0]  XADR_VEC  = ADDR_W'(cpu_pkg::XADR_VEC)
) (
    input  logic [ADDR_W-1:0] pc_i,
    input  state_e            state_i,
    input  logic              irq_pend_i,
    input  logic [2:0]        pc_src_i,
    input  logic              br_taken_i,
    input  logic [ADDR_W-1:0] con_ba_i,
    input  logic [JT_W-1:0]   jt_i,
    input  logic [ADDR_W-1:0] jr_target_i,
    output logic [ADDR_W-1:0] pc_plus4_o,
    output logic [ADDR_W-1:0] next_pc_o,
    output state_e            next_state_o,
    output logic [ADDR_W-1:0] epc_next_o,
    output logic              exc_o,
    output logic              irq_take_o
);

    localparam int MSB = ADDR_W - 1;
    localparam logic [ADDR_W-2:0] STEP = {{(ADDR_W-4){1'b0}}, 3'd4};

    logic [ADDR_W-1:0] j_pc;
    logic [ADDR_W-1:0] norm_pc;
    logic              illop;
    logic              unused_con_msb;

    assign unused_con_msb = con_ba_i[MSB];

    always_comb begin
        pc_plus4_o = {pc_i[MSB], pc_i[MSB-1:0] + STEP};

        // Jump target is a word address; privilege bit comes from the current PC
        j_pc              = '0;
        j_pc[JT_W+1:2]    = jt_i;
        j_pc[MSB]         = pc_i[MSB];

        case (pc_src_i)
            PC_SRC_BR: norm_pc = br_taken_i ? {pc_i[MSB], con_ba_i[MSB-1:0]}
                                            : pc_plus4_o;
            PC_SRC_J:  norm_pc = j_pc;
            PC_SRC_JR: norm_pc = (state_i == S_KERNEL)
                               ? jr_target_i
                               : {1'b0, jr_target_i[MSB-1:0]};
            default:   norm_pc = pc_plus4_o;
        endcase

        illop      = (pc_src_i == PC_SRC_ILLOP);
        irq_take_o = irq_pend_i && (state_i == S_USER) && !illop;
        exc_o      = illop || irq_take_o;

        if (illop)
            next_pc_o = ILLOP_VEC;
        else if (irq_take_o)
            next_pc_o = XADR_VEC;
        else
            next_pc_o = norm_pc;

        epc_next_o   = illop ? pc_plus4_o : norm_pc;
        next_state_o = state_e'(next_pc_o[MSB]);
    end

endmodule

// File: rtl/pc_sequencer.sv
// PC register, privilege FSM, latched interrupt and exception entry.
// Define PC_EPC_EN to build the exception-PC capture register.
module pc_sequencer
    import cpu_pkg::*;
#(
    parameter int                 ADDR_W    = 32,
    parameter int                 JT_W      = 26,
    parameter logic [ADDR_W-1:0]  RESET_VEC = ADDR_W'(cpu_pkg::RESET_VEC),
    parameter logic [ADDR_W-1:0]  ILLOP_VEC = ADDR_W'(cpu_pkg::ILLOP_VEC),
    parameter logic [ADDR_W-1:0]  XADR_VEC  = ADDR_W'(cpu_pkg::XADR_VEC)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic [2:0]        pc_src,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] con_ba,
    input  logic [JT_W-1:0]   jt,
    input  logic [ADDR_W-1:0] jr_target,
    input  logic              irq,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus4,
    output logic              kernel,
    output logic              exc_taken,
    output logic [ADDR_W-1:0] epc
);

    logic [ADDR_W-1:0] pc_q;
    state_e            state_q;
    logic              irq_pend_q;
    logic              irq_pend_d;
    logic              exc_q;

    logic [ADDR_W-1:0] next_pc;
    state_e            next_state;
    logic [ADDR_W-1:0] epc_next;
    logic              exc;
    logic              irq_take;

    pc_next_mux #(
        .ADDR_W    (ADDR_W),
        .JT_W      (JT_W),
        .ILLOP_VEC (ILLOP_VEC),
        .XADR_VEC  (XADR_VEC)
    ) u_mux (
        .pc_i         (pc_q),
        .state_i      (state_q),
        .irq_pend_i   (irq_pend_q),
        .pc_src_i     (pc_src),
        .br_taken_i   (br_taken),
        .con_ba_i     (con_ba),
        .jt_i         (jt),
        .jr_target_i  (jr_target),
        .pc_plus4_o   (pc_plus4),
        .next_pc_o    (next_pc),
        .next_state_o (next_state),
        .epc_next_o   (epc_next),
        .exc_o        (exc),
        .irq_take_o   (irq_take)
    );

    // Kernel-mode irq is masked; a taken irq clears the latch outright
    always_comb begin
        irq_pend_d = irq_pend_q || (irq && (state_q == S_USER));
        if (!stall && irq_take)
            irq_pend_d = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q       <= RESET_VEC;
            state_q    <= S_KERNEL;
            irq_pend_q <= 1'b0;
            exc_q      <= 1'b0;
        end else begin
            irq_pend_q <= irq_pend_d;
            exc_q      <= !stall && exc;
            if (!stall) begin
                pc_q    <= next_pc;
                state_q <= next_state;
            end
        end
    end

`ifdef PC_EPC_EN
    logic [ADDR_W-1:0] epc_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            epc_q <= '0;
        else if (!stall && exc)
            epc_q <= epc_next;
    end

    assign epc = epc_q;
`else
    logic unused_epc_next;

    assign unused_epc_next = ^epc_next;
    assign epc             = '0;
`endif

    assign pc        = pc_q;
    assign kernel    = pc_q[ADDR_W-1];
    assign exc_taken = exc_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomised self-checking bench for pc_sequencer against a spec-level model.
// Honours PC_EPC_EN for the expected epc value.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic [2:0]  pc_src;
    logic        br_taken;
    logic [31:0] con_ba;
    logic [25:0] jt;
    logic [31:0] jr_target;
    logic        irq;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        kernel;
    logic        exc_taken;
    logic [31:0] epc;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_pc;
    logic [31:0] m_epc;
    bit          m_pend;
    bit          m_exc;

    pc_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .stall     (stall),
        .pc_src    (pc_src),
        .br_taken  (br_taken),
        .con_ba    (con_ba),
        .jt        (jt),
        .jr_target (jr_target),
        .irq       (irq),
        .pc        (pc),
        .pc_plus4  (pc_plus4),
        .kernel    (kernel),
        .exc_taken (exc_taken),
        .epc       (epc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_epc();
`ifdef PC_EPC_EN
        return m_epc;
`else
        return 32'h0;
`endif
    endfunction

    task automatic compare_all();
        chk("pc", pc, m_pc);
        chk("pc_plus4", pc_plus4, {m_pc[31], m_pc[30:0] + 31'd4});
        chk("kernel", {31'b0, kernel}, {31'b0, m_pc[31]});
        chk("exc_taken", {31'b0, exc_taken}, {31'b0, m_exc});
        chk("epc", epc, exp_epc());
    endtask

    task automatic model_reset();
        m_pc   = 32'h8000_0000;
        m_pend = 1'b0;
        m_exc  = 1'b0;
        m_epc  = 32'h0;
    endtask

    task automatic model_edge();
        logic [31:0] p4;
        logic [31:0] nrm;
        bit          user;
        bit          pend_set;
        user     = !m_pc[31];
        pend_set = irq && user;
        p4       = {m_pc[31], m_pc[30:0] + 31'd4};
        if (stall) begin
            m_exc  = 1'b0;
            m_pend = m_pend | pend_set;
        end else begin
            case (pc_src)
                3'd1:    nrm = br_taken ? {m_pc[31], con_ba[30:0]} : p4;
                3'd2:    nrm = {m_pc[31], 3'b000, jt, 2'b00};
                3'd3:    nrm = user ? {1'b0, jr_target[30:0]} : jr_target;
                default: nrm = p4;
            endcase
            if (pc_src == 3'd4) begin
                m_pc   = 32'h8000_0004;
                m_exc  = 1'b1;
                m_epc  = p4;
                m_pend = m_pend | pend_set;
            end else if (m_pend && user) begin
                m_pc   = 32'h8000_0008;
                m_exc  = 1'b1;
                m_epc  = nrm;
                m_pend = 1'b0;
            end else begin
                m_pc   = nrm;
                m_exc  = 1'b0;
                m_pend = m_pend | pend_set;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic async_reset();
        reset = 1'b1;
        #2;
        model_reset();
        compare_all();
        reset = 1'b0;
        #1;
    endtask

    task automatic drive(input bit st, input logic [2:0] src, input bit br,
                         input logic [31:0] cb, input logic [25:0] j,
                         input logic [31:0] jr, input bit ir);
        stall     = st;
        pc_src    = src;
        br_taken  = br;
        con_ba    = cb;
        jt        = j;
        jr_target = jr;
        irq       = ir;
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 3'd0, 0, 32'h0, 26'h0, 32'h0, 0);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        compare_all();
        reset = 1'b0;

        tick();
        async_reset();
        chk("rst_pc", pc, 32'h8000_0000);
        chk("rst_kernel", {31'b0, kernel}, 32'h1);

        repeat (3) tick();
        chk("seq3", pc, 32'h8000_000C);

        drive(0, 3'd3, 0, 32'h0, 26'h0, 32'h0000_0100, 0);
        tick();
        chk("kjr_pc", pc, 32'h0000_0100);
        chk("kjr_user", {31'b0, kernel}, 32'h0);

        drive(0, 3'd1, 1, 32'h8000_0200, 26'h0, 32'h0, 0);
        tick();
        chk("br_msb", pc, 32'h0000_0200);

        drive(0, 3'd3, 0, 32'h0, 26'h0, 32'h8000_0040, 0);
        tick();
        chk("ujr_pc", pc, 32'h0000_0040);
        chk("ujr_user", {31'b0, kernel}, 32'h0);

        drive(0, 3'd3, 0, 32'h0, 26'h0, 32'h0000_0100, 0);
        tick();
        drive(1, 3'd0, 0, 32'h0, 26'h0, 32'h0, 1);
        tick();
        chk("stall_hold", pc, 32'h0000_0100);
        drive(0, 3'd0, 0, 32'h0, 26'h0, 32'h0, 0);
        tick();
        chk("irq_pc", pc, 32'h8000_0008);
        chk("irq_exc", {31'b0, exc_taken}, 32'h1);
`ifdef PC_EPC_EN
        chk("irq_epc", epc, 32'h0000_0104);
`endif
        tick();
        chk("irq_pulse", {31'b0, exc_taken}, 32'h0);

        drive(0, 3'd3, 0, 32'h0, 26'h0, 32'h0000_0100, 0);
        tick();
        drive(1, 3'd0, 0, 32'h0, 26'h0, 32'h0, 1);
        tick();
        drive(0, 3'd4, 0, 32'h0, 26'h0, 32'h0, 0);
        tick();
        chk("illop_pc", pc, 32'h8000_0004);
        drive(0, 3'd3, 0, 32'h0, 26'h0, 32'h0000_0108, 0);
        tick();
        chk("ret_pc", pc, 32'h0000_0108);
        drive(0, 3'd0, 0, 32'h0, 26'h0, 32'h0, 0);
        tick();
        chk("pend_kept", pc, 32'h8000_0008);

        drive(0, 3'd3, 0, 32'h0, 26'h0, 32'h0000_0100, 0);
        tick();
        drive(1, 3'd0, 0, 32'h0, 26'h0, 32'h0, 1);
        tick();
        irq = 1'b0;
        async_reset();
        chk("rst_stall_pc", pc, 32'h8000_0000);
        chk("rst_stall_epc", epc, 32'h0);
        drive(0, 3'd3, 0, 32'h0, 26'h0, 32'h0000_0200, 0);
        tick();
        drive(0, 3'd0, 0, 32'h0, 26'h0, 32'h0, 0);
        tick();
        chk("pend_cleared", pc, 32'h0000_0204);

        drive(0, 3'd4, 0, 32'h0, 26'h0, 32'h0, 0);
        tick();
        drive(0, 3'd3, 0, 32'h0, 26'h0, 32'hFFFF_FFFC, 0);
        tick();
        drive(0, 3'd0, 0, 32'h0, 26'h0, 32'h0, 0);
        tick();
        chk("wrap_k", pc, 32'h8000_0000);
        drive(0, 3'd3, 0, 32'h0, 26'h0, 32'h7FFF_FFFC, 0);
        tick();
        drive(0, 3'd0, 0, 32'h0, 26'h0, 32'h0, 0);
        tick();
        chk("wrap_u", pc, 32'h0000_0000);

        drive(0, 3'd2, 0, 32'h0, 26'h3FF_FFFF, 32'h0, 0);
        tick();
        chk("j_user", pc, 32'h0FFF_FFFC);
        drive(0, 3'd4, 0, 32'h0, 26'h0, 32'h0, 0);
        tick();
        drive(0, 3'd2, 0, 32'h0, 26'h2AA_AAAA, 32'h0, 0);
        tick();
        chk("j_kernel", pc, 32'h8AAA_AAA8);
        drive(0, 3'd1, 0, 32'h1234_5678, 26'h0, 32'h0, 0);
        tick();
        chk("br_nt", pc, 32'h8AAA_AAAC);

        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 3) == 0,
                  3'($urandom_range(0, 7)),
                  $urandom_range(0, 1) == 1,
                  $urandom, 26'($urandom), $urandom,
                  $urandom_range(0, 4) == 0);
            if ($urandom_range(0, 99) == 0)
                async_reset();
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Parametrised next-generation program-counter block for the MIPS core; owns the PC register, next-PC selection, privilege (kernel/user) tracking and exception/interrupt entry.
- Adds the following behaviour:
  - stall hold
  - a latched interrupt-pending flag
  - enforced privilege on jumps
  - an optional exception-PC (EPC) capture register
- Feeds instruction fetch; takes branch/jump/register targets from decode/ALU and control from the main controller.

Parameters:
- ADDR_W, 32: PC width; MSB (bit ADDR_W-1) is the kernel/supervisor bit.
- JT_W, 26: jump-target field width.
- RESET_VEC, 32'h8000_0000: PC after reset; kernel mode.
- ILLOP_VEC, 32'h8000_0004: illegal-instruction handler address.
- XADR_VEC, 32'h8000_0008: interrupt handler address.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- stall  in  1  hold PC this cycle.
- pc_src  in  3  0 seq, 1 branch, 2 jump, 3 jr, 4 illop, 5-7 reserved (treated as seq).
- br_taken  in  1  branch condition from ALU, used when pc_src=1.
- con_ba  in  ADDR_W  branch target (PC+4+offset<<2).
- jt  in  JT_W  jump-target field.
- jr_target  in  ADDR_W  register-jump target (databus A).
- irq  in  1  level interrupt request.
- pc  out  ADDR_W  current PC.
- pc_plus4  out  ADDR_W  {pc[MSB], pc[MSB-1:0]+4}; carry never alters MSB.
- kernel  out  1  equals pc[ADDR_W-1].
- exc_taken  out  1  registered one-cycle pulse: redirect to ILLOP_VEC or XADR_VEC occurred on the last edge.
- epc  out  ADDR_W  saved return address (see Optional Feature).

Behaviour:
- Reset (async, any time, including mid-stall or mid-exception):
  - pc=RESET_VEC, state=S_KERNEL, irq_pend=0, exc_taken=0, epc=0.
- FSM states: S_USER, S_KERNEL. State always mirrors pc MSB after each edge.
- Next PC (computed when stall=0), in priority order:
  1. pc_src=4 -> ILLOP_VEC, state S_KERNEL, exc_taken=1.
  2. irq_pend=1 and state=S_USER -> XADR_VEC, state S_KERNEL, exc_taken=1, irq_pend cleared.
  3. pc_src=1: br_taken ? {pc[MSB], con_ba[MSB-1:0]} : pc_plus4.
  4. pc_src=2: {pc[MSB], zero-fill, jt, 2'b00}. The low 2 bits are forced 00 to word-align the target, so jt is a word address; total width=ADDR_W.
  5. pc_src=3 in S_KERNEL -> jr_target verbatim; MSB=0 transitions S_KERNEL->S_USER (exception return).
  6. pc_src=3 in S_USER -> {1'b0, jr_target[MSB-1:0]}; user code can never enter kernel via jr.
  7. Otherwise (0, 5-7) -> pc_plus4.
- Privilege: branches and jumps preserve the MSB; only exceptions set it; only kernel jr clears it.
- irq_pend: set on any edge where irq=1 and state=S_USER (stalled or not). Held while in kernel. Taken on the first non-stalled user-mode cycle.
- irq in kernel: masked, not latched. If irq is still high after the return to user, it is latched on that cycle and taken on the next cycle.
- Stall=1: pc, state and epc hold; exc_taken=0. pc_src (including illop) is ignored, so the controller must re-present it. irq_pend may still set.
- Simultaneous illop and pending irq: illop wins; irq_pend is retained and taken after return to user.
- Wrap: pc_plus4 at {MSB, all-ones-minus-3} wraps the low bits to 0 with MSB kept.
- Latency: all redirects take effect on the next rising edge; no bubbles generated internally.

Optional Feature:
- Macro PC_EPC_EN.
- Defined:
  - On illop entry, epc <= pc_plus4 (return past the offending instruction).
  - On irq entry, epc <= the next PC that would otherwise have been loaded, so no instruction is lost.
  - epc holds otherwise.
- Undefined: no epc register; epc output tied to 0; handlers rely on software-saved $k0.

Decomposition:
- Shared package cpu_pkg holds:
  - PC_SRC_SEQ/BR/J/JR/ILLOP encodings,
  - the state enum {S_USER, S_KERNEL},
  - the default vectors RESET_VEC, ILLOP_VEC, XADR_VEC.
- One natural sub-module, pc_next_mux: purely combinational next-PC/privilege selection. pc_sequencer keeps the registers, irq_pend, FSM and EPC.

Test Plan:
- Reset → sequential: assert reset mid-cycle, release → pc=8000_0000, kernel=1; 3 cycles pc_src=0 → pc=8000_000C.
- Kernel jr → user, then branch: kernel jr jr_target=0000_0100 → pc=0000_0100, kernel=0; then pc_src=1, br_taken=1, con_ba=8000_0200 → pc=0000_0200 (MSB kept 0).
- User jr privilege: in user, jr jr_target=8000_0040 → pc=0000_0040, kernel stays 0.
- Interrupt under stall: at pc=0000_0100 in user, stall=1 with irq pulsed 1 cycle → pc holds. Stall=0 → pc=8000_0008, exc_taken=1 for one cycle; with PC_EPC_EN, epc=0000_0104.
- Illop beats pending irq: illop with irq_pend=1 → pc=8000_0004 and irq_pend retained; kernel jr to 0000_0108 → next cycle pc=8000_0008.
- Reset during stall: reset pulse during stall with irq_pend=1 → pc=8000_0000, irq_pend=0, epc=0.
